// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, qualifies a synchronised lock signal,
// and releases the core reset once lock has held; re-resets the PLL on timeout or loss.
module pll_lock_supervisor #(
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned PLL_RST_CYCLES     = 16,
  parameter int unsigned LOCK_TIMEOUT       = 50000,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned RESET_HOLD_CYCLES  = 256,
  parameter int unsigned CNT_W              = 20
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked_in,
  output logic       pll_rst,
  output logic       core_reset,
  output logic       ready,
  output logic [7:0] relock_count
);

  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RESET_HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_HOLD      = 3'd3,
    S_RUN       = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic             r_pll_rst;
  logic             r_core_reset;
  logic             r_ready;
  logic [7:0]       r_relock_count;
  logic             w_locked_s;
  logic             w_lost_in_run;

  assign w_locked_s   = r_sync[SYNC_STAGES-1];
  assign pll_rst      = r_pll_rst;
  assign core_reset   = r_core_reset;
  assign ready        = r_ready;
  assign relock_count = r_relock_count;

  // Next-state logic; lock detection wins over the timeout in WAIT_LOCK
  always_comb begin
    w_next        = r_state;
    w_lost_in_run = 1'b0;
    case (r_state)
      S_PLL_RST: begin
        if (r_cnt == PLL_RST_LAST) w_next = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (w_locked_s)                 w_next = S_STABLE;
        else if (r_cnt == TIMEOUT_LAST) w_next = S_PLL_RST;
      end
      S_STABLE: begin
        if (!w_locked_s)               w_next = S_WAIT_LOCK;
        else if (r_cnt == STABLE_LAST) w_next = S_HOLD;
      end
      S_HOLD: begin
        if (!w_locked_s)             w_next = S_PLL_RST;
        else if (r_cnt == HOLD_LAST) w_next = S_RUN;
      end
      S_RUN: begin
        if (!w_locked_s) begin
          w_next        = S_PLL_RST;
          w_lost_in_run = 1'b1;
        end
      end
      default: w_next = S_PLL_RST;
    endcase
  end

  // State, counter, synchroniser and Moore outputs registered from the next state
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state        <= S_PLL_RST;
      r_cnt          <= '0;
      r_sync         <= '0;
      r_relock_count <= 8'd0;
      r_pll_rst      <= 1'b1;
      r_core_reset   <= 1'b1;
      r_ready        <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_sync       <= {r_sync[SYNC_STAGES-2:0], locked_in};
      r_pll_rst    <= (w_next == S_PLL_RST);
      r_core_reset <= (w_next != S_RUN);
      r_ready      <= (w_next == S_RUN);
      if ((w_next != r_state) || (r_state == S_RUN)) r_cnt <= '0;
      else                                            r_cnt <= r_cnt + CNT_W'(1);
      if (w_lost_in_run && (r_relock_count != 8'hFF))
        r_relock_count <= r_relock_count + 8'd1;
    end
  end

endmodule
